uart_bus_host: RTL
==================

Name: uart_bus_host

Overview:
- Bus initiator that drives the memory-mapped UART peripheral from the host side: it issues register writes and reads on the peripheral's we/address/data bus.
- Transmit path: takes bytes from a valid/ready stream, writes the TX data register, sets the send bit, and polls until the peripheral clears it.
- Receive path: polls the control register for the "new" flag, reads the RX data register, clears the flag, and emits the byte on a valid pulse.
- Sits between host logic (e.g. a test pattern generator or command parser) and the UART peripheral top.

Parameters:
- CTRL_ADDR, 32'h0000_0000, control register address (bit0 = send, bit1 = new).
- TXD_ADDR, 32'h0000_0008, TX data register address (low 8 bits = byte to send).
- RXD_ADDR, 32'h0000_000C, RX data register address (low 8 bits = received byte).
- POLL_DIV, 16, idle cycles between control-register polls; minimum 1.
- SEND_TIMEOUT, 100000, max WAIT_SEND polls before abort; minimum 1.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- we_o  out  1  bus write strobe, one cycle per write
- address_o  out  32  bus address
- data_o  out  32  bus write data
- data_i  in  32  bus read data; combinational from address_o
- tx_data_i  in  8  byte to transmit
- tx_valid_i  in  1  tx_data_i valid
- tx_ready_o  out  1  host accepts a byte when tx_valid_i && tx_ready_o
- rx_data_o  out  8  received byte, held until next rx_valid_o
- rx_valid_o  out  1  one-cycle pulse, rx_data_o new
- tx_err_o  out  1  one-cycle pulse, send timeout abort
- busy_o  out  1  FSM not in IDLE

Behaviour:
- All outputs are registered. Reset (reset_i = 0, asynchronous):
  - state = IDLE; poll counter = 0; timeout counter = 0.
  - we_o = 0, address_o = 0, data_o = 0, rx_data_o = 0, rx_valid_o = 0, tx_err_o = 0, busy_o = 0.
  - tx_ready_o = 0 during reset; goes to 1 the first cycle after release.
- Bus rules:
  - Write: address_o, data_o and we_o = 1 are valid for exactly one cycle.
  - Read: address_o is presented with we_o = 0, and data_i is sampled on the following clock edge (address held 2 cycles total).
- States:
  - IDLE: tx_ready_o = 1; poll counter increments.
    - On a tx handshake: latch the byte, tx_ready_o -> 0, go to WR_TXD.
    - Otherwise, when the poll counter reaches POLL_DIV-1: clear it, go to RD_CTRL.
    - A handshake and a poll expiry in the same cycle: tx wins; the poll counter holds and the poll is deferred.
  - WR_TXD: write TXD_ADDR = {24'b0, byte} -> WR_SEND.
  - WR_SEND: write CTRL_ADDR = 32'h1; clear timeout counter -> WAIT_SEND.
  - WAIT_SEND: read CTRL_ADDR.
    - bit0 = 0 -> IDLE.
    - bit0 = 1: increment timeout counter; when it reaches SEND_TIMEOUT -> ABORT.
    - bit1 seen set is remembered (pend_new) and serviced from IDLE via RD_CTRL immediately, bypassing POLL_DIV.
  - ABORT: write CTRL_ADDR = 32'h0; pulse tx_err_o -> IDLE.
  - RD_CTRL: read CTRL_ADDR.
    - bit1 = 1 -> RD_RXD.
    - bit1 = 0 -> IDLE.
    - Clear pend_new.
  - RD_RXD: read RXD_ADDR; latch data_i[7:0] into rx_data_o -> CLR_NEW.
  - CLR_NEW: write CTRL_ADDR = {30'b0, 1'b0, sampled bit0}, which preserves an in-flight send; pulse rx_valid_o the same cycle -> IDLE.
- RX has no backpressure: bytes arriving faster than the poll period overwrite in the peripheral (peripheral-side loss, not flagged here).
- busy_o = (state != IDLE).
- Reset mid-transaction: immediate return to IDLE, we_o drops asynchronously, and the latched tx byte is discarded.
- Counter widths: $clog2 of the respective parameter + 1; no wrap-around inside a count.

Test Plan:
- Reset then idle, data_i = 0, POLL_DIV = 4 -> a read of address 0x0 every 6 cycles (4 idle + 2 read); we_o never high; tx_ready_o = 1 from the first cycle after reset.
- tx_data_i = 8'hA5 handshake; data_i bit0 = 1 for 3 polls then 0 -> writes 0x8 = 32'h0000_00A5 then 0x0 = 32'h1; 3 busy polls; return to IDLE with tx_ready_o = 1 and tx_err_o never pulsed.
- Control read returns 32'h2, RXD read returns 32'h0000_003C -> rx_data_o = 8'h3C with a one-cycle rx_valid_o; a write of 32'h0 to 0x0 in the same cycle.
- SEND_TIMEOUT = 5, bit0 stuck at 1 -> exactly 5 WAIT_SEND reads, a write of 32'h0 to 0x0, and a one-cycle tx_err_o pulse.
- During WAIT_SEND, data_i = 32'h3 then 32'h0 -> after the tx completes, RD_CTRL is issued within 1 cycle (no POLL_DIV wait).
- If that RD_CTRL sample reads 32'h3, the CLR_NEW write must be 32'h1.
- Assert reset_i low during WR_SEND -> we_o low in the same cycle; after release, no further write to 0x0 with 32'h1 without a new handshake.

Source files
------------

// File: rtl/uart_bus_host.sv
// rtl/uart_bus_host.sv - bus initiator driving the memory-mapped UART peripheral (tx stream in, rx pulses out)
module uart_bus_host #(
  parameter logic [31:0] CTRL_ADDR    = 32'h0000_0000,
  parameter logic [31:0] TXD_ADDR     = 32'h0000_0008,
  parameter logic [31:0] RXD_ADDR     = 32'h0000_000C,
  parameter int          POLL_DIV     = 16,
  parameter int          SEND_TIMEOUT = 100000
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        we_o,
  output logic [31:0] address_o,
  output logic [31:0] data_o,
  input  logic [31:0] data_i,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  output logic        tx_err_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    IDLE, WR_TXD, WR_SEND, WAIT_SEND, ABORT, RD_CTRL, RD_RXD, CLR_NEW
  } state_t;

  localparam int PW = $clog2(POLL_DIV) + 1;
  localparam int TW = $clog2(SEND_TIMEOUT) + 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_DIV - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(SEND_TIMEOUT);

  state_t        state_q, state_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          pend_new_q, pend_new_d;
  logic          ctrl_bit0_q, ctrl_bit0_d;
  logic          rd_phase_q, rd_phase_d;
  logic          we_q, we_d;
  logic [31:0]   address_q, address_d;
  logic [31:0]   data_q, data_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          tx_err_q, tx_err_d;
  logic          busy_q, busy_d;
  logic          tx_ready_q, tx_ready_d;
  logic          tx_fire;
  logic          unused_data;

  assign unused_data = ^data_i[31:8];
  assign tx_fire     = tx_valid_i && tx_ready_q && (state_q == IDLE);

  always_comb begin
    state_d     = state_q;
    poll_cnt_d  = poll_cnt_q;
    to_cnt_d    = to_cnt_q;
    tx_byte_d   = tx_byte_q;
    pend_new_d  = pend_new_q;
    ctrl_bit0_d = ctrl_bit0_q;
    rd_phase_d  = 1'b0;
    rx_data_d   = rx_data_q;
    address_d   = address_q;
    data_d      = data_q;
    we_d        = 1'b0;
    rx_valid_d  = 1'b0;
    tx_err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_fire) begin
          // A poll that expires on the handshake cycle stays pending for the return to IDLE.
          tx_byte_d = tx_data_i;
          state_d   = WR_TXD;
          if (poll_cnt_q != POLL_LAST) poll_cnt_d = poll_cnt_q + 1'b1;
        end else if (pend_new_q || poll_cnt_q == POLL_LAST) begin
          poll_cnt_d = '0;
          state_d    = RD_CTRL;
        end else begin
          poll_cnt_d = poll_cnt_q + 1'b1;
        end
      end
      WR_TXD:  state_d = WR_SEND;
      WR_SEND: begin
        to_cnt_d = '0;
        state_d  = WAIT_SEND;
      end
      WAIT_SEND: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          pend_new_d = pend_new_q | data_i[1];
          if (!data_i[0]) begin
            state_d = IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
            if (to_cnt_d == TO_LAST) state_d = ABORT;
          end
        end
      end
      ABORT: state_d = IDLE;
      RD_CTRL: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          pend_new_d  = 1'b0;
          ctrl_bit0_d = data_i[0];
          state_d     = data_i[1] ? RD_RXD : IDLE;
        end
      end
      RD_RXD: begin
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          rx_data_d = data_i[7:0];
          state_d   = CLR_NEW;
        end
      end
      CLR_NEW: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they follow the state being entered.
    case (state_d)
      WR_TXD: begin
        we_d = 1'b1; address_d = TXD_ADDR; data_d = {24'b0, tx_byte_d};
      end
      WR_SEND: begin
        we_d = 1'b1; address_d = CTRL_ADDR; data_d = 32'h1;
      end
      ABORT: begin
        we_d = 1'b1; address_d = CTRL_ADDR; data_d = 32'h0; tx_err_d = 1'b1;
      end
      CLR_NEW: begin
        we_d = 1'b1; address_d = CTRL_ADDR; data_d = {31'b0, ctrl_bit0_q}; rx_valid_d = 1'b1;
      end
      WAIT_SEND, RD_CTRL: address_d = CTRL_ADDR;
      RD_RXD:             address_d = RXD_ADDR;
      default: ;
    endcase

    busy_d     = (state_d != IDLE);
    tx_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q     <= IDLE;
      poll_cnt_q  <= '0;
      to_cnt_q    <= '0;
      tx_byte_q   <= '0;
      pend_new_q  <= 1'b0;
      ctrl_bit0_q <= 1'b0;
      rd_phase_q  <= 1'b0;
      we_q        <= 1'b0;
      address_q   <= '0;
      data_q      <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_err_q    <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      poll_cnt_q  <= poll_cnt_d;
      to_cnt_q    <= to_cnt_d;
      tx_byte_q   <= tx_byte_d;
      pend_new_q  <= pend_new_d;
      ctrl_bit0_q <= ctrl_bit0_d;
      rd_phase_q  <= rd_phase_d;
      we_q        <= we_d;
      address_q   <= address_d;
      data_q      <= data_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_err_q    <= tx_err_d;
      busy_q      <= busy_d;
      tx_ready_q  <= tx_ready_d;
    end
  end

  assign we_o       = we_q;
  assign address_o  = address_q;
  assign data_o     = data_q;
  assign rx_data_o  = rx_data_q;
  assign rx_valid_o = rx_valid_q;
  assign tx_err_o   = tx_err_q;
  assign busy_o     = busy_q;
  assign tx_ready_o = tx_ready_q;

endmodule
